// File: rtl/cronometro_param.sv
// Parametrised stopwatch: tick divider, MM:SS or plain decimal count, lap freeze, 4x 7-seg.
// Optional macro CRONOMETRO_BLANK_EN blanks leading-zero digits.
module cronometro_param #(
   parameter int unsigned CLK_FREQ    = 50000000,
   parameter int unsigned TICK_HZ     = 1,
   parameter int unsigned MINSEC_MODE = 1,
   parameter int unsigned MAX_COUNT   = 10000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   output logic       running,
   output logic       frozen,
   output logic       tick,
   output logic [6:0] dis0,
   output logic [6:0] dis1,
   output logic [6:0] dis2,
   output logic [6:0] dis3
);

   localparam int unsigned DIV_MAX = CLK_FREQ / TICK_HZ - 1;
   localparam int unsigned DIV_W   = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
   localparam logic [15:0] CNT_LAST = 16'(MAX_COUNT - 1);

   typedef enum logic {
      STOPPED,
      RUNNING
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [15:0]       count_q, count_d;
   logic [15:0]       lap_val_q, lap_val_d;
   logic              frozen_q, frozen_d;
   logic              start_stop_q, clear_q, lap_in_q;
   logic              ss_edge, clr_edge, lap_edge;
   logic              tick_w;
   logic [15:0]       live_digits, disp_digits;
   logic              blank1, blank2, blank3;

   // Active-low segments, bit 0 = a ... bit 6 = g.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   // In MM:SS mode the count is already BCD; in plain mode it is binary.
   function automatic logic [15:0] count_inc(input logic [15:0] c);
      logic [15:0] r;
      r = c;
      if (MINSEC_MODE != 0) begin
         if (c[3:0] != 4'd9) begin
            r[3:0] = c[3:0] + 4'd1;
         end else begin
            r[3:0] = '0;
            if (c[7:4] != 4'd5) begin
               r[7:4] = c[7:4] + 4'd1;
            end else begin
               r[7:4] = '0;
               if (c[11:8] != 4'd9) begin
                  r[11:8] = c[11:8] + 4'd1;
               end else begin
                  r[11:8] = '0;
                  r[15:12] = (c[15:12] != 4'd5) ? c[15:12] + 4'd1 : '0;
               end
            end
         end
      end else begin
         r = (c == CNT_LAST) ? '0 : c + 16'd1;
      end
      return r;
   endfunction

   function automatic logic [15:0] to_digits(input logic [15:0] c);
      logic [13:0] v;
      logic [15:0] r;
      v = c[13:0];
      if (MINSEC_MODE != 0) begin
         r = c;
      end else begin
         r[3:0]   = 4'(v % 14'd10);
         r[7:4]   = 4'((v / 14'd10) % 14'd10);
         r[11:8]  = 4'((v / 14'd100) % 14'd10);
         r[15:12] = 4'(v / 14'd1000);
      end
      return r;
   endfunction

   assign ss_edge  = start_stop & ~start_stop_q;
   assign clr_edge = clear & ~clear_q;
   assign lap_edge = lap & ~lap_in_q;
   assign tick_w   = (state_q == RUNNING) && (div_q == DIV_W'(DIV_MAX));

   always_comb begin
      state_d = state_q;
      if (ss_edge) begin
         state_d = (state_q == STOPPED) ? RUNNING : STOPPED;
      end
   end

   // Clear wins over a coincident tick; lap captures the post-update count.
   always_comb begin
      div_d     = div_q;
      count_d   = count_q;
      frozen_d  = frozen_q;
      lap_val_d = lap_val_q;
      if (clr_edge) begin
         div_d   = '0;
         count_d = '0;
      end else if (state_q == RUNNING) begin
         div_d = tick_w ? '0 : div_q + 1'b1;
         if (tick_w) begin
            count_d = count_inc(count_q);
         end
      end
      if (clr_edge) begin
         frozen_d = 1'b0;
      end else if (lap_edge) begin
         frozen_d = ~frozen_q;
         if (!frozen_q) begin
            lap_val_d = to_digits(count_d);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= STOPPED;
         div_q        <= '0;
         count_q      <= '0;
         lap_val_q    <= '0;
         frozen_q     <= 1'b0;
         start_stop_q <= 1'b0;
         clear_q      <= 1'b0;
         lap_in_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         count_q      <= count_d;
         lap_val_q    <= lap_val_d;
         frozen_q     <= frozen_d;
         start_stop_q <= start_stop;
         clear_q      <= clear;
         lap_in_q     <= lap;
      end
   end

   always_comb begin
      live_digits = to_digits(count_q);
      disp_digits = frozen_q ? lap_val_q : live_digits;
   end

`ifdef CRONOMETRO_BLANK_EN
   always_comb begin
      blank3 = (disp_digits[15:12] == 4'd0);
      blank2 = 1'b0;
      blank1 = 1'b0;
      if (MINSEC_MODE == 0) begin
         blank2 = blank3 && (disp_digits[11:8] == 4'd0);
         blank1 = blank2 && (disp_digits[7:4] == 4'd0);
      end
   end
`else
   always_comb begin
      blank3 = 1'b0;
      blank2 = 1'b0;
      blank1 = 1'b0;
   end
`endif

   assign dis0    = seg7(disp_digits[3:0]);
   assign dis1    = blank1 ? '1 : seg7(disp_digits[7:4]);
   assign dis2    = blank2 ? '1 : seg7(disp_digits[11:8]);
   assign dis3    = blank3 ? '1 : seg7(disp_digits[15:12]);
   assign running = (state_q == RUNNING);
   assign frozen  = frozen_q;
   assign tick    = tick_w;

endmodule

// File: tb/tb_cronometro_param.sv
// Bench for cronometro_param: MM:SS instance and plain mod-100 instance on shared stimulus,
// checked each cycle against an arithmetic model, plus directed literal checks.
module tb_cronometro_param;

   logic       clk, rst_n, ss, cl, lp;
   logic       run_a, frz_a, tick_a, run_b, frz_b, tick_b;
   logic [6:0] a0, a1, a2, a3, b0, b1, b2, b3;

   int checks = 0;
   int errors = 0;

   cronometro_param #(.CLK_FREQ(10), .TICK_HZ(1), .MINSEC_MODE(1), .MAX_COUNT(10000)) dut_a (
      .clk(clk), .rst_n(rst_n), .start_stop(ss), .clear(cl), .lap(lp),
      .running(run_a), .frozen(frz_a), .tick(tick_a),
      .dis0(a0), .dis1(a1), .dis2(a2), .dis3(a3));

   cronometro_param #(.CLK_FREQ(10), .TICK_HZ(1), .MINSEC_MODE(0), .MAX_COUNT(100)) dut_b (
      .clk(clk), .rst_n(rst_n), .start_stop(ss), .clear(cl), .lap(lp),
      .running(run_b), .frozen(frz_b), .tick(tick_b),
      .dis0(b0), .dis1(b1), .dis2(b2), .dis3(b3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                       7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                       7'b0000000, 7'b0010000};
`ifdef CRONOMETRO_BLANK_EN
   localparam logic [6:0] ZLEAD = 7'b1111111;
`else
   localparam logic [6:0] ZLEAD = 7'b1000000;
`endif

   // Model: elapsed ticks as plain integers, displayed modulo the wrap period.
   bit m_run, m_frz, p_ss, p_cl, p_lp;
   int m_ph, m_a, m_b, m_lap_a, m_lap_b;

   always @(posedge clk) begin
      bit e_ss, e_cl, e_lp, term;
      if (!rst_n) begin
         m_run = 0; m_frz = 0; m_ph = 0; m_a = 0; m_b = 0; m_lap_a = 0; m_lap_b = 0;
         p_ss = 0; p_cl = 0; p_lp = 0;
      end else begin
         e_ss = ss && !p_ss;
         e_cl = cl && !p_cl;
         e_lp = lp && !p_lp;
         term = m_run && (m_ph == 9);
         if (e_cl) begin
            m_ph = 0; m_a = 0; m_b = 0;
         end else if (m_run) begin
            if (term) begin
               m_ph = 0;
               m_a = (m_a + 1) % 3600;
               m_b = (m_b + 1) % 100;
            end else begin
               m_ph = m_ph + 1;
            end
         end
         if (e_ss) m_run = !m_run;
         if (e_cl) m_frz = 0;
         else if (e_lp) begin
            if (!m_frz) begin
               m_frz = 1; m_lap_a = m_a; m_lap_b = m_b;
            end else begin
               m_frz = 0;
            end
         end
         p_ss = ss; p_cl = cl; p_lp = lp;
      end
   end

   function automatic int digit(input int v, input bit mmss, input int pos);
      int mm, sec;
      mm = v / 60;
      sec = v % 60;
      if (mmss) begin
         case (pos)
            0: return sec % 10;
            1: return sec / 10;
            2: return mm % 10;
            default: return mm / 10;
         endcase
      end
      case (pos)
         0: return v % 10;
         1: return (v / 10) % 10;
         2: return (v / 100) % 10;
         default: return (v / 1000) % 10;
      endcase
   endfunction

   function automatic logic [6:0] exp_seg(input int v, input bit mmss, input int pos);
      bit blank;
      blank = 0;
`ifdef CRONOMETRO_BLANK_EN
      if (mmss) blank = (pos == 3) && (digit(v, mmss, 3) == 0);
      else if (pos > 0) begin
         blank = 1;
         for (int p = pos; p < 4; p++) if (digit(v, mmss, p) != 0) blank = 0;
      end
`endif
      return blank ? 7'b1111111 : SEG[digit(v, mmss, pos)];
   endfunction

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      int va, vb;
      va = m_frz ? m_lap_a : m_a;
      vb = m_frz ? m_lap_b : m_b;
      chk("running_a", 7'(run_a), 7'(m_run));
      chk("frozen_a", 7'(frz_a), 7'(m_frz));
      chk("tick_a", 7'(tick_a), 7'(m_run && m_ph == 9));
      chk("running_b", 7'(run_b), 7'(m_run));
      chk("frozen_b", 7'(frz_b), 7'(m_frz));
      chk("tick_b", 7'(tick_b), 7'(m_run && m_ph == 9));
      chk("dis0_a", a0, exp_seg(va, 1, 0));
      chk("dis1_a", a1, exp_seg(va, 1, 1));
      chk("dis2_a", a2, exp_seg(va, 1, 2));
      chk("dis3_a", a3, exp_seg(va, 1, 3));
      chk("dis0_b", b0, exp_seg(vb, 0, 0));
      chk("dis1_b", b1, exp_seg(vb, 0, 1));
      chk("dis2_b", b2, exp_seg(vb, 0, 2));
      chk("dis3_b", b3, exp_seg(vb, 0, 3));
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_tick(input string name);
      int n;
      n = 0;
      while (!tick_a && n < 20) begin
         step(1);
         n++;
      end
      chk(name, 7'(tick_a), 7'd1);
   endtask

   initial begin
      int ticks, n;
      rst_n = 0; ss = 0; cl = 0; lp = 0;
      step(2);
      chk("lit_reset_running", 7'(run_a), 7'd0);
      chk("lit_reset_tick", 7'(tick_a), 7'd0);
      chk("lit_reset_dis0", a0, SEG[0]);
      chk("lit_reset_dis2", a2, SEG[0]);
      chk("lit_reset_dis3", a3, ZLEAD);
      chk("lit_reset_b_dis0", b0, SEG[0]);
      rst_n = 1;

      ss = 1; step(1); ss = 0;
      ticks = 0;
      repeat (600) begin
         step(1);
         if (tick_a) ticks++;
      end
      chk("lit_ticks_in_600", 7'(ticks), 7'd60);
      chk("lit_0100_dis0", a0, SEG[0]);
      chk("lit_0100_dis1", a1, SEG[0]);
      chk("lit_0100_dis2", a2, SEG[1]);
      chk("lit_0100_dis3", a3, ZLEAD);

      step(35390);
      chk("lit_5959_dis0", a0, SEG[9]);
      chk("lit_5959_dis1", a1, SEG[5]);
      chk("lit_5959_dis2", a2, SEG[9]);
      chk("lit_5959_dis3", a3, SEG[5]);
      step(10);
      chk("lit_wrap_dis0", a0, SEG[0]);
      chk("lit_wrap_dis2", a2, SEG[0]);
      chk("lit_wrap_b_dis0", b0, SEG[0]);

      step(50);
      chk("lit_0005_dis0", a0, SEG[5]);
      lp = 1; step(1); lp = 0;
      step(29);
      chk("lit_lap_hold_dis0", a0, SEG[5]);
      chk("lit_lap_hold_frozen", 7'(frz_a), 7'd1);
      lp = 1; step(1); lp = 0;
      chk("lit_lap_release_dis0", a0, SEG[8]);
      chk("lit_lap_release_frozen", 7'(frz_a), 7'd0);

      step(5);
      ss = 1; step(1); ss = 0;
      step(50);
      chk("lit_stopped", 7'(run_a), 7'd0);
      ss = 1;
      n = 0;
      do begin
         step(1);
         ss = 0;
         n++;
      end while (!tick_a && n < 20);
      chk("lit_restart_tick_delay", 7'(n), 7'd3);

      lp = 1; step(1); lp = 0;
      chk("lit_lap_post_update", a0, SEG[9]);
      wait_tick("lit_tick_at_0009");
      cl = 1; step(1); cl = 0;
      chk("lit_clear_dis0", a0, SEG[0]);
      chk("lit_clear_dis1", a1, SEG[0]);
      chk("lit_clear_frozen", 7'(frz_a), 7'd0);
      chk("lit_clear_running", 7'(run_a), 7'd1);

      step(420);
      chk("lit_42_b_dis0", b0, SEG[2]);
      chk("lit_42_b_dis1", b1, SEG[4]);
      chk("lit_42_b_dis2", b2, ZLEAD);
      chk("lit_42_b_dis3", b3, ZLEAD);
      chk("lit_42_a_dis1", a1, SEG[4]);

      rst_n = 0; step(1); rst_n = 1;
      chk("lit_midrun_reset_running", 7'(run_a), 7'd0);
      chk("lit_midrun_reset_dis1", a1, SEG[0]);

      ss = 1;
      repeat (4000) begin
         step(1);
         if ($urandom_range(0, 29) == 0) ss = ~ss;
         cl = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 39) == 0) lp = ~lp;
         rst_n = ($urandom_range(0, 999) != 0);
      end
      rst_n = 1; ss = 0; cl = 0; lp = 0;
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cronometro_param.md
Name: cronometro_param

Overview:
- Parametrised stopwatch for the FPGA board, successor to the fixed 1 Hz seconds counter.
- Divides the board clock to a configurable tick, counts MM:SS (or 0..MAX_COUNT-1 in plain mode).
- Drives four 7-segment displays through the team's digit decoder.
- Adds start/stop, clear and lap-freeze control from debounced board pushbuttons.

Parameters:
- CLK_FREQ, 50000000, input clock frequency in Hz.
- TICK_HZ, 1, count increments per second (tick period = CLK_FREQ/TICK_HZ cycles).
- MINSEC_MODE, 1, 1 = MM:SS rollover (seconds wrap 59, minutes wrap 59); 0 = plain decimal count 0..MAX_COUNT-1.
- MAX_COUNT, 10000, wrap limit in plain mode (≤ 10000, fits 4 digits).

Ports:
- clk  input  1  board clock.
- rst_n  input  1  synchronous active-low reset.
- start_stop  input  1  level from button; rising edge toggles run/stop.
- clear  input  1  level; rising edge zeroes count (any state).
- lap  input  1  level; rising edge toggles display freeze.
- running  output  1  1 while counting.
- frozen  output  1  1 while display is lap-frozen.
- tick  output  1  one-cycle pulse on each count increment.
- dis0  output  7  units digit, segments [0:6], active-low, from the team's decoder.
- dis1  output  7  tens digit.
- dis2  output  7  hundreds digit (minutes units in MM:SS).
- dis3  output  7  thousands digit (minutes tens in MM:SS).

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst_n).
- Reset values:
  - State = STOPPED; divider, count and lap register = 0.
  - running = 0, frozen = 0, tick = 0.
  - All displays show "0".
- Edge detection:
  - Each control input is registered once.
  - edge = in & ~in_q, so there is 1 cycle of latency from input to action.
  - Inputs are already debounced upstream.
- FSM states:
  - STOPPED --start_stop edge--> RUNNING.
  - RUNNING --start_stop edge--> STOPPED.
  - clear edge does not change state.
- Divider:
  - Counts only in RUNNING, range 0..CLK_FREQ/TICK_HZ-1.
  - At the terminal value: wraps to 0, tick = 1 for that cycle, count increments on the same edge.
  - Entering STOPPED holds the divider value; resuming continues from it with no reset.
- Count:
  - MM:SS mode: stored as four BCD digits.
  - Seconds units wrap 9→0 and carry; seconds tens wrap 5→0 and carry.
  - Minutes follow the same pattern; 59:59 → 00:00.
  - Plain mode: binary counter wrapping MAX_COUNT-1 → 0; BCD conversion is combinational (/10, %10 chain).
- clear edge:
  - Divider and count go to 0 on the next edge; frozen goes to 0.
  - Has priority over a simultaneous tick.
  - Simultaneous start_stop edge still toggles state.
- lap edge:
  - frozen 0→1: the lap register captures the count value after the current edge's update.
  - frozen 1→0: the display returns to the live count.
  - Counting continues underneath while frozen.
- Display source = frozen ? lap register : live count, fed to 4 decoder instances.
- Reset asserted mid-run: returns to the reset state on that edge; no partial update.

Optional Feature:
- Macro CRONOMETRO_BLANK_EN.
- Defined: leading-zero digits dis3, dis2 and dis1 are blanked (7'b1111111) when they and all higher digits are 0; dis0 is never blanked. In MM:SS mode only dis3 blanks.
- Undefined: all digits are always shown.

Test Plan:
- Setup: CLK_FREQ=10, TICK_HZ=1 for simulation speed.
- Reset with rst_n=0 for 2 cycles -> running=0, all displays show "0", tick=0.
- start_stop pulse, run 600 cycles -> 60 ticks, display 01:00; tick is exactly one cycle wide every 10 cycles.
- Preload via run to 59:59, 1 more tick -> 00:00, no glitch on intermediate digits.
- Run to 00:05, lap pulse, wait 30 cycles -> display stays 00:05, live count 00:08; second lap pulse -> display shows 00:08.
- Stop mid-divider at phase 7, wait 50 cycles, restart -> next tick occurs 3 cycles after restart.
- clear on the same cycle as a tick at 00:09 -> count 00:00, frozen=0, running unchanged.
- MINSEC_MODE=0, MAX_COUNT=100, 100 ticks -> wraps to 0 and shows "0".
- With CRONOMETRO_BLANK_EN -> dis3/dis2 blanked for value 42.
